stack_alu: RTL and testbench
============================

# stack_alu

Sequenced arithmetic/logic unit directly downstream of the CPU data stack. Consumes the stack's top-of-stack (A) and next-on-stack (B) read ports, computes a Forth-style result, and drives the stack's write data, store strobe and function code to commit it. Logical and compare ops finish in one cycle. Multiply, divide and modulo are iterative, with a start/busy/done handshake to the CPU control sequencer.

## Interface
- WIDTH, 16: data width; must match the stack's WIDTH.
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; sampled only when o_busy=0.
- i_op  in  4  opcode, sampled with i_start.
- i_A  in  WIDTH  top of stack (stack o_read_A).
- i_B  in  WIDTH  next on stack (stack o_read_B).
- o_busy  out  1  iterative op in progress.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  WIDTH  result; drives stack i_write_D.
- o_store  out  1  one-cycle store pulse, coincident with o_done; drives stack i_store.
- o_function  out  3  stack function code, valid while o_store=1; FN_NONE otherwise.
- o_zero  out  1  o_result==0; valid with o_done.
- o_carry  out  1  ADD carry-out or SUB borrow; 0 for other ops; valid with o_done.
- o_error  out  1  divide-by-zero or unsupported opcode; valid with o_done.

## Operation
- Opcodes:
  - 0 ADD B+A; 1 SUB B-A; 2 AND; 3 OR; 4 XOR.
  - 5 INVERT ~A; 6 NEGATE -A; 7 SHL1 A<<1; 8 SHR1 arithmetic A>>>1.
  - 9 EQ B==A; 10 LT signed B<A; 11 ULT unsigned B<A.
  - 12 MUL, low WIDTH bits of B*A; 13 DIV unsigned B/A; 14 MOD unsigned B%A; 15 reserved.
- Compare results are all-ones for true and 0 for false.
- Function code: binary ops (0-4, 9-14) issue FN_POP2_PUSH1. Unary ops (5-8) issue FN_REPLACE_TOP.
- i_A, i_B and i_op are latched on the accepted i_start edge. Later stack changes do not affect the op.
- States:
  - IDLE: on i_start go to RESULT for single-cycle ops, or to CALC with counter=WIDTH for MUL/DIV/MOD.
  - CALC: one shift-add (MUL) or restoring-subtract (DIV/MOD) step per cycle. Counter decrements; at 1 go to RESULT.
  - RESULT: pulse o_done and o_store, present flags, return to IDLE.
- i_start while o_busy=1 is ignored, with no queueing.
- Divide by zero (A=0): no iteration; next cycle o_done with DIV result all-ones, MOD result B, o_error=1, o_store=1.
- Opcode 15: o_done next cycle, o_error=1, o_store=0, o_function=FN_NONE, o_result=0.
- Reset (any time, including mid-CALC): state IDLE, all outputs 0, o_function=FN_NONE, counter 0. No done or store is emitted for the aborted op.
- o_result, o_zero, o_carry and o_error hold their value until the next o_done.

## Timing
- Start accepted at rising edge k.
- Single-cycle op: o_done/o_store high during cycle k+1.
- MUL/DIV/MOD: o_busy high in cycles k+1 through k+WIDTH; o_done in cycle k+WIDTH+1 with o_busy=0.
- Back-to-back: a start asserted during the o_done cycle is accepted at the end of that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- STACK_ALU_DIVIDE_EN defined: the restoring divider is built, and opcodes 13/14 behave as above.
- Not defined: opcodes 13/14 are treated as opcode 15, with o_error=1 and no store after one cycle. MUL is unaffected.

## Structure
- Shared package stack_pkg holds:
  - opcode constants OP_ADD..OP_MOD;
  - stack function codes FN_NONE=3'd0, FN_REPLACE_TOP=3'd1, FN_POP2_PUSH1=3'd2;
  - ALU state encoding.
- The stack block imports the same package, so both sides agree on the function codes.
- One sub-module, iter_muldiv, holds the shared shift register, accumulator and iteration counter for MUL and DIV/MOD. The divider path sits under STACK_ALU_DIVIDE_EN. stack_alu owns decode, single-cycle datapath, FSM and output registers.

## Test plan
- ADD: B=16'hFFFF, A=16'h0001. Cycle k+1 shows o_done=1, o_store=1, o_result=0, o_zero=1, o_carry=1, o_function=FN_POP2_PUSH1.
- SUB/INVERT:
  - SUB with B=5, A=7 gives 16'hFFFE, o_carry=1.
  - INVERT with A=16'h00FF gives 16'hFF00 and o_function=FN_REPLACE_TOP.
- Compare: B=16'h8000, A=16'h0001. LT gives 16'hFFFF; ULT gives 16'h0000.
- MUL: B=16'h0123, A=16'h0010. o_busy holds for 16 cycles and o_done comes exactly 17 cycles after the start edge with 16'h1230. A second i_start in cycle k+5 is ignored.
- DIV/MOD (macro on):
  - B=100, A=7: DIV gives 14, MOD gives 2, done at k+17.
  - A=0: DIV gives 16'hFFFF, MOD gives 100, o_error=1, done at k+1.
  - Macro off: opcode 13 gives o_error=1 and o_store=0.
- Reset: drive i_reset_n low at cycle k+5 of a MUL. All outputs go to 0 immediately. After release, no o_done or o_store occurs for 20 cycles.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: definitions shared by the CPU data stack and stack_alu.
//   op_e      : ALU opcodes, sampled on i_op with i_start
//   fn_e      : stack function codes driven on o_function / stack i_function
//   alu_state_e : stack_alu sequencer states
//   md_mode_e : operation selector for the iterative multiply/divide unit
package stack_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_INVERT = 4'd5,
        OP_NEGATE = 4'd6,
        OP_SHL1   = 4'd7,
        OP_SHR1   = 4'd8,
        OP_EQ     = 4'd9,
        OP_LT     = 4'd10,
        OP_ULT    = 4'd11,
        OP_MUL    = 4'd12,
        OP_DIV    = 4'd13,
        OP_MOD    = 4'd14,
        OP_RSVD   = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        FN_NONE        = 3'd0,
        FN_REPLACE_TOP = 3'd1,
        FN_POP2_PUSH1  = 3'd2
    } fn_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_RESULT = 2'd2
    } alu_state_e;

    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_MOD = 2'd2
    } md_mode_e;

endpackage

// File: rtl/stack_alu_iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle multiplier and (optionally) restoring divider.
// Build option: STACK_ALU_DIVIDE_EN builds the divider; without it only MUL.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_load           : latch operands and start WIDTH iterations
//   i_mode           : MD_MUL / MD_DIV / MD_MOD
//   i_a, i_b         : top (A) and next (B) of stack
//   o_last           : the step being taken this cycle is the final one
//   o_result         : value the current step produces (final answer when o_last)
module iter_muldiv
    import stack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  md_mode_e         i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    // sreg: multiplier (MUL) or dividend shifting into quotient (DIV/MOD)
    // acc : partial product or partial remainder
    // opnd: multiplicand (shifted left per step) or divisor (static)
    logic [WIDTH-1:0] sreg, acc, opnd;
    logic [WIDTH-1:0] sreg_n, acc_n, opnd_n;

`ifdef STACK_ALU_DIVIDE_EN
    md_mode_e       mode;
    logic [WIDTH:0] rem_sh, trial;

    assign rem_sh = {acc, sreg[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, opnd};
`else
    logic unused_mode;
    assign unused_mode = ^i_mode;
`endif

    always_comb begin
        acc_n  = sreg[0] ? acc + opnd : acc;
        opnd_n = opnd << 1;
        sreg_n = sreg >> 1;
`ifdef STACK_ALU_DIVIDE_EN
        if (mode != MD_MUL) begin
            opnd_n = opnd;
            // Restoring step: keep the shifted remainder when the trial borrows.
            if (trial[WIDTH]) begin
                acc_n  = rem_sh[WIDTH-1:0];
                sreg_n = {sreg[WIDTH-2:0], 1'b0};
            end else begin
                acc_n  = trial[WIDTH-1:0];
                sreg_n = {sreg[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

`ifdef STACK_ALU_DIVIDE_EN
    assign o_result = (mode == MD_DIV) ? sreg_n : acc_n;
`else
    assign o_result = acc_n;
`endif

    assign o_last = (cnt == CW'(1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt  <= '0;
            sreg <= '0;
            acc  <= '0;
            opnd <= '0;
`ifdef STACK_ALU_DIVIDE_EN
            mode <= MD_MUL;
`endif
        end else if (i_load) begin
            cnt <= CW'(WIDTH);
            acc <= '0;
`ifdef STACK_ALU_DIVIDE_EN
            mode <= i_mode;
            if (i_mode == MD_MUL) begin
                sreg <= i_a;
                opnd <= i_b;
            end else begin
                sreg <= i_b;
                opnd <= i_a;
            end
`else
            sreg <= i_a;
            opnd <= i_b;
`endif
        end else if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
            acc  <= acc_n;
            sreg <= sreg_n;
            opnd <= opnd_n;
        end
    end

endmodule

// File: rtl/stack_alu.sv
// stack_alu: Forth-style ALU sitting under the CPU data stack.
// Build option: STACK_ALU_DIVIDE_EN enables DIV/MOD (opcodes 13/14); otherwise
// they report an error like the reserved opcode.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_start, i_op    : request and opcode (sampled only when not busy)
//   i_A, i_B         : top / next of stack, latched on accept
//   o_busy, o_done   : iterative op in progress / one-cycle completion
//   o_result         : result to stack write data (held until next done)
//   o_store          : store pulse with o_done
//   o_function       : stack function code while o_store, else FN_NONE
//   o_zero, o_carry, o_error : flags, valid with o_done
module stack_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_store,
    output logic [2:0]       o_function,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_error
);

    alu_state_e       state;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry, sc_error, sc_store, sc_iter;
    fn_e              sc_fn;
    md_mode_e         sc_mode;
    logic             md_load, md_last;
    logic [WIDTH-1:0] md_result;

    // Decode plus single-cycle datapath; sc_iter marks ops handed to iter_muldiv.
    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_error  = 1'b0;
        sc_store  = 1'b1;
        sc_iter   = 1'b0;
        sc_fn     = FN_POP2_PUSH1;
        sc_mode   = MD_MUL;
        case (i_op)
            OP_ADD:    {sc_carry, sc_result} = {1'b0, i_B} + {1'b0, i_A};
            OP_SUB:    {sc_carry, sc_result} = {1'b0, i_B} - {1'b0, i_A};
            OP_AND:    sc_result = i_B & i_A;
            OP_OR:     sc_result = i_B | i_A;
            OP_XOR:    sc_result = i_B ^ i_A;
            OP_INVERT: begin sc_result = ~i_A; sc_fn = FN_REPLACE_TOP; end
            OP_NEGATE: begin sc_result = -i_A; sc_fn = FN_REPLACE_TOP; end
            OP_SHL1:   begin sc_result = {i_A[WIDTH-2:0], 1'b0}; sc_fn = FN_REPLACE_TOP; end
            OP_SHR1:   begin sc_result = {i_A[WIDTH-1], i_A[WIDTH-1:1]}; sc_fn = FN_REPLACE_TOP; end
            OP_EQ:     sc_result = {WIDTH{i_B == i_A}};
            OP_LT:     sc_result = {WIDTH{$signed(i_B) < $signed(i_A)}};
            OP_ULT:    sc_result = {WIDTH{i_B < i_A}};
            OP_MUL:    sc_iter = 1'b1;
`ifdef STACK_ALU_DIVIDE_EN
            OP_DIV, OP_MOD: begin
                sc_mode = (i_op == OP_DIV) ? MD_DIV : MD_MOD;
                // Divide by zero short-circuits: no iterations.
                if (i_A == '0) begin
                    sc_result = (i_op == OP_DIV) ? '1 : i_B;
                    sc_error  = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
`endif
            default: begin
                sc_error = 1'b1;
                sc_store = 1'b0;
                sc_fn    = FN_NONE;
            end
        endcase
    end

    assign md_load = i_start && (state != ST_CALC) && sc_iter;

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (md_load),
        .i_mode    (sc_mode),
        .i_a       (i_A),
        .i_b       (i_B),
        .o_last    (md_last),
        .o_result  (md_result)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_result   <= '0;
            o_store    <= 1'b0;
            o_function <= FN_NONE;
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_store    <= 1'b0;
            o_function <= FN_NONE;
            case (state)
                // RESULT accepts a new start just like IDLE (back-to-back ops).
                ST_IDLE, ST_RESULT: begin
                    state <= ST_IDLE;
                    if (i_start) begin
                        if (sc_iter) begin
                            state  <= ST_CALC;
                            o_busy <= 1'b1;
                        end else begin
                            state      <= ST_RESULT;
                            o_done     <= 1'b1;
                            o_store    <= sc_store;
                            o_function <= sc_fn;
                            o_result   <= sc_result;
                            o_zero     <= (sc_result == '0);
                            o_carry    <= sc_carry;
                            o_error    <= sc_error;
                        end
                    end
                end
                ST_CALC: begin
                    if (md_last) begin
                        state      <= ST_RESULT;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_store    <= 1'b1;
                        o_function <= FN_POP2_PUSH1;
                        o_result   <= md_result;
                        o_zero     <= (md_result == '0);
                        o_carry    <= 1'b0;
                        o_error    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: randomized self-checking bench for stack_alu with an
// arithmetic reference model; honours STACK_ALU_DIVIDE_EN like the design.
module tb_stack_alu;

    localparam logic [2:0] FN_NONE = 3'd0;
    localparam logic [2:0] FN_REPL = 3'd1;
    localparam logic [2:0] FN_POP2 = 3'd2;

    logic        clk, rst_n, i_start;
    logic [3:0]  i_op;
    logic [15:0] i_A, i_B;
    logic        o_busy, o_done, o_store, o_zero, o_carry, o_error;
    logic [15:0] o_result;
    logic [2:0]  o_function;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    stack_alu #(.WIDTH(16)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_A        (i_A),
        .i_B        (i_B),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_result   (o_result),
        .o_store    (o_store),
        .o_function (o_function),
        .o_zero     (o_zero),
        .o_carry    (o_carry),
        .o_error    (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        err;
        logic        st;
        logic [2:0]  fn;
        logic        iter;
    } ref_t;

    function automatic ref_t ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        ref_t t;
        logic [31:0] w;
        t = '{r: 16'h0, c: 1'b0, err: 1'b0, st: 1'b1, fn: FN_POP2, iter: 1'b0};
        case (op)
            4'd0:  begin w = 32'(b) + 32'(a); t.r = w[15:0]; t.c = w[16]; end
            4'd1:  begin t.r = b - a; t.c = (b < a); end
            4'd2:  t.r = b & a;
            4'd3:  t.r = b | a;
            4'd4:  t.r = b ^ a;
            4'd5:  begin t.r = ~a; t.fn = FN_REPL; end
            4'd6:  begin t.r = 16'h0 - a; t.fn = FN_REPL; end
            4'd7:  begin t.r = a << 1; t.fn = FN_REPL; end
            4'd8:  begin t.r = 16'($signed(a) >>> 1); t.fn = FN_REPL; end
            4'd9:  t.r = (b == a) ? 16'hFFFF : 16'h0000;
            4'd10: t.r = ($signed(b) < $signed(a)) ? 16'hFFFF : 16'h0000;
            4'd11: t.r = (b < a) ? 16'hFFFF : 16'h0000;
            4'd12: begin w = 32'(b) * 32'(a); t.r = w[15:0]; t.iter = 1'b1; end
`ifdef STACK_ALU_DIVIDE_EN
            4'd13: if (a == 16'h0) begin t.r = 16'hFFFF; t.err = 1'b1; end
                   else begin t.r = b / a; t.iter = 1'b1; end
            4'd14: if (a == 16'h0) begin t.r = b; t.err = 1'b1; end
                   else begin t.r = b % a; t.iter = 1'b1; end
`endif
            default: begin t.err = 1'b1; t.st = 1'b0; t.fn = FN_NONE; end
        endcase
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: expected outputs for the cycle after each edge.
    ref_t cur, pend;
    int   busy_left;
    logic e_busy, e_done, e_store, e_zero, e_carry, e_error;
    logic [15:0] e_result;
    logic [2:0]  e_fn;

    assign cur = ref_op(i_op, i_A, i_B);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            pend      <= '0;
            e_busy    <= 1'b0;
            e_done    <= 1'b0;
            e_store   <= 1'b0;
            e_fn      <= FN_NONE;
            e_result  <= 16'h0;
            e_zero    <= 1'b0;
            e_carry   <= 1'b0;
            e_error   <= 1'b0;
        end else begin
            e_done  <= 1'b0;
            e_store <= 1'b0;
            e_fn    <= FN_NONE;
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    e_busy   <= 1'b0;
                    e_done   <= 1'b1;
                    e_store  <= 1'b1;
                    e_fn     <= FN_POP2;
                    e_result <= pend.r;
                    e_zero   <= (pend.r == 16'h0);
                    e_carry  <= 1'b0;
                    e_error  <= 1'b0;
                end
            end else if (i_start) begin
                if (cur.iter) begin
                    busy_left <= 16;
                    e_busy    <= 1'b1;
                    pend      <= cur;
                end else begin
                    e_done   <= 1'b1;
                    e_store  <= cur.st;
                    e_fn     <= cur.fn;
                    e_result <= cur.r;
                    e_zero   <= (cur.r == 16'h0);
                    e_carry  <= cur.c;
                    e_error  <= cur.err;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",     32'(o_busy),     32'(e_busy));
            check("done",     32'(o_done),     32'(e_done));
            check("store",    32'(o_store),    32'(e_store));
            check("function", 32'(o_function), 32'(e_fn));
            check("result",   32'(o_result),   32'(e_result));
            check("zero",     32'(o_zero),     32'(e_zero));
            check("carry",    32'(o_carry),    32'(e_carry));
            check("error",    32'(o_error),    32'(e_error));
        end
    end

    // Called just after a negedge; returns at the negedge of the cycle after accept.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_A     = a;
        i_B     = b;
        @(negedge clk);
        i_start = 1'b0;
        i_op    = 4'($urandom);
        i_A     = 16'($urandom);
        i_B     = 16'($urandom);
    endtask

    task automatic wait_done(input string name, input int lat, input logic [15:0] res, input logic err);
        for (int j = 1; j <= lat; j++) begin
            check({name, "_done"}, 32'(o_done), 32'(j == lat));
            if (j == lat) begin
                check({name, "_result"}, 32'(o_result), 32'(res));
                check({name, "_error"},  32'(o_error),  32'(err));
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        ref_t p;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_op    = 4'd0;
        i_A     = 16'h0;
        i_B     = 16'h0;

        // Pin the model against hand-computed values.
        p = ref_op(4'd0, 16'h0001, 16'hFFFF);
        check("model_add_r", 32'(p.r), 32'h0);
        check("model_add_c", 32'(p.c), 32'h1);
        p = ref_op(4'd1, 16'd7, 16'd5);
        check("model_sub_r", 32'(p.r), 32'hFFFE);
        p = ref_op(4'd5, 16'h00FF, 16'h0);
        check("model_inv_fn", 32'(p.fn), 32'(FN_REPL));
        p = ref_op(4'd10, 16'h0001, 16'h8000);
        check("model_lt_r", 32'(p.r), 32'hFFFF);
        p = ref_op(4'd12, 16'h0010, 16'h0123);
        check("model_mul_r", 32'(p.r), 32'h1230);
        p = ref_op(4'd15, 16'h1, 16'h1);
        check("model_rsvd_st", 32'(p.st), 32'h0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("reset_result", 32'(o_result), 32'h0);
        check("reset_done",   32'(o_done),   32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'd0, 16'h0001, 16'hFFFF);
        check("add_done",  32'(o_done),     32'h1);
        check("add_store", 32'(o_store),    32'h1);
        check("add_res",   32'(o_result),   32'h0);
        check("add_zero",  32'(o_zero),     32'h1);
        check("add_carry", 32'(o_carry),    32'h1);
        check("add_fn",    32'(o_function), 32'(FN_POP2));
        issue(4'd1, 16'd7, 16'd5);
        check("sub_res",   32'(o_result),   32'hFFFE);
        check("sub_carry", 32'(o_carry),    32'h1);
        issue(4'd5, 16'h00FF, 16'h1234);
        check("inv_res",   32'(o_result),   32'hFF00);
        check("inv_fn",    32'(o_function), 32'(FN_REPL));
        issue(4'd10, 16'h0001, 16'h8000);
        check("lt_res",    32'(o_result),   32'hFFFF);
        issue(4'd11, 16'h0001, 16'h8000);
        check("ult_res",   32'(o_result),   32'h0);

        issue(4'd12, 16'h0010, 16'h0123);
        for (int j = 1; j <= 17; j++) begin
            check("mul_busy", 32'(o_busy), 32'(j <= 16));
            check("mul_done", 32'(o_done), 32'(j == 17));
            i_start = (j == 5);
            if (j == 5) i_op = 4'd0;
            if (j == 17) check("mul_res", 32'(o_result), 32'h1230);
            else @(negedge clk);
        end

`ifdef STACK_ALU_DIVIDE_EN
        issue(4'd13, 16'd7, 16'd100);
        wait_done("div", 17, 16'd14, 1'b0);
        issue(4'd14, 16'd7, 16'd100);
        wait_done("mod", 17, 16'd2, 1'b0);
        issue(4'd13, 16'd0, 16'd100);
        wait_done("div0", 1, 16'hFFFF, 1'b1);
        check("div0_store", 32'(o_store), 32'h1);
        issue(4'd14, 16'd0, 16'd100);
        wait_done("mod0", 1, 16'd100, 1'b1);
`else
        issue(4'd13, 16'd7, 16'd100);
        check("nodiv_done",  32'(o_done),     32'h1);
        check("nodiv_error", 32'(o_error),    32'h1);
        check("nodiv_store", 32'(o_store),    32'h0);
        check("nodiv_fn",    32'(o_function), 32'(FN_NONE));
`endif
        issue(4'd15, 16'd3, 16'd4);
        wait_done("rsvd", 1, 16'h0, 1'b1);

        // Reset in the middle of a multiply.
        issue(4'd12, 16'd3, 16'd5);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(o_busy),   32'h0);
        check("rst_result", 32'(o_result), 32'h0);
        check("rst_fn",     32'(o_function), 32'(FN_NONE));
        check("rst_error",  32'(o_error),  32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("post_rst_done",  32'(o_done),  32'h0);
            check("post_rst_store", 32'(o_store), 32'h0);
        end

        // Randomized traffic, including starts while busy and rare resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                i_start = 1'b0;
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end else begin
                i_start = ($urandom_range(0, 2) == 0);
                i_op    = 4'($urandom_range(0, 15));
                i_A     = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                i_B     = 16'($urandom);
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
